// File: rtl/irom_responder.sv
// Instruction-ROM responder: accepts PC fetch requests, reads a word-addressed ROM and
// returns the instruction (or a NOP with an error flag) after a fixed LATENCY.
module irom_responder #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH_LOG2 = 10,
    parameter int                LATENCY    = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pc_valid_i,
    input  logic [ADDR_W-1:0]     pc_addr_i,
    output logic                  pc_ready_o,
    input  logic                  flush_i,
    output logic                  inst_valid_o,
    output logic [DATA_W-1:0]     inst_data_o,
    output logic                  inst_err_o,
    input  logic                  ld_we_i,
    input  logic [DEPTH_LOG2-1:0] ld_addr_i,
    input  logic [DATA_W-1:0]     ld_data_i
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DATA_W-1:0] NOP     = DATA_W'(32'h0000_0013);
    // Range bounds carry one extra bit so the upper limit never wraps.
    localparam logic [ADDR_W:0]   BASE_X  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0]   LIMIT_X = BASE_X + ((ADDR_W+1)'(1) << (DEPTH_LOG2 + 2));

    if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
        $error("irom_responder: LATENCY must be in 1..7");
    end

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [LATENCY-1:0]    r_vld;
    logic [LATENCY-1:0]    r_err;
    logic [DATA_W-1:0]     r_dat [LATENCY];

    logic                  w_accept;
    logic [ADDR_W-1:0]     w_off;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [ADDR_W:0]       w_addr_x;
    logic                  w_misalign;
    logic                  w_below;
    logic                  w_above;
    logic                  w_err;

    // Loader writes and fetches never share an edge because a write drops ready.
    assign pc_ready_o = !ld_we_i && !flush_i;
    assign w_accept   = pc_valid_i && pc_ready_o;

    assign w_off      = pc_addr_i - BASE_ADDR;
    assign w_idx      = DEPTH_LOG2'(w_off >> 2);
    assign w_addr_x   = {1'b0, pc_addr_i};
    assign w_misalign = |pc_addr_i[1:0];
    assign w_below    = w_addr_x < BASE_X;
    assign w_above    = w_addr_x >= LIMIT_X;
    assign w_err      = w_misalign || w_below || w_above;

    always_ff @(posedge clk) begin
        if (ld_we_i) begin
            r_mem[ld_addr_i] <= ld_data_i;
        end
    end

    // Stage 0 captures the synchronous read; later stages only delay it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_err <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_dat[k] <= '0;
            end
        end else begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
                r_err[0] <= w_err;
                r_dat[0] <= w_err ? NOP : r_mem[w_idx];
            end
            for (int k = 1; k < LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1] && !flush_i;
                r_err[k] <= r_err[k-1];
                r_dat[k] <= r_dat[k-1];
            end
        end
    end

    assign inst_valid_o = r_vld[LATENCY-1];
    assign inst_data_o  = r_vld[LATENCY-1] ? r_dat[LATENCY-1] : '0;
    assign inst_err_o   = r_vld[LATENCY-1] && r_err[LATENCY-1];

endmodule

// File: tb/tb_irom_responder.sv
// Bench for irom_responder: a LATENCY=2/BASE=0 instance and a LATENCY=1/BASE=0x100
// instance share one stimulus stream and are checked against a queue-based model.
module tb_irom_responder;

  localparam logic [31:0] BASE1 = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pv = 1'b0;
  logic [31:0] pa = '0;
  logic        fl = 1'b0;
  logic        we = 1'b0;
  logic [9:0]  wa = '0;
  logic [31:0] wd = '0;

  logic        rdy2, v2, e2;
  logic [31:0] d2;
  logic        rdy1, v1, e1;
  logic [31:0] d1;

  always #5 clk = ~clk;

  irom_responder #(.LATENCY(2), .BASE_ADDR(32'h0)) dut2 (
    .clk(clk), .rst_n(rst_n), .pc_valid_i(pv), .pc_addr_i(pa), .pc_ready_o(rdy2),
    .flush_i(fl), .inst_valid_o(v2), .inst_data_o(d2), .inst_err_o(e2),
    .ld_we_i(we), .ld_addr_i(wa), .ld_data_i(wd)
  );

  irom_responder #(.LATENCY(1), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pc_valid_i(pv), .pc_addr_i(pa), .pc_ready_o(rdy1),
    .flush_i(fl), .inst_valid_o(v1), .inst_data_o(d1), .inst_err_o(e1),
    .ld_we_i(we), .ld_addr_i(wa), .ld_data_i(wd)
  );

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } ent_t;

  ent_t        q2[$];
  ent_t        q1[$];
  logic [31:0] mdl_mem [1024];
  int          edge_n = 0;
  int          total = 0;
  int          bad = 0;
  int          acc1 = 0, acc2 = 0, resp1 = 0, resp2 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a, input logic [31:0] base);
    logic [32:0] lim;
    lim = {1'b0, base} + 33'h1000;
    return (a[1:0] != 2'b00) || (a < base) || ({1'b0, a} >= lim);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] base);
    logic [31:0] off;
    off = a - base;
    if (bad_addr(a, base)) return 32'h0000_0013;
    return mdl_mem[off[11:2]];
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      1: return 32'($urandom_range(0, 4400));
      2: return 32'h0000_1000 + 32'($urandom_range(0, 64)) * 4;
      default: return $urandom;
    endcase
  endfunction

  // One clock: drive at negedge, model the edge, check outputs at the next negedge.
  task automatic step(input logic v, input logic [31:0] a, input logic f,
                      input logic w, input logic [9:0] wadr, input logic [31:0] wdat);
    ent_t        en;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
    pv = v; pa = a; fl = f; we = w; wa = wadr; wd = wdat;
    #1;
    chk("ready2", rdy2, !w && !f);
    chk("ready1", rdy1, !w && !f);
    @(posedge clk);
    edge_n++;
    if (f) begin
      q1.delete();
      q2.delete();
    end
    if (v && !w && !f) begin
      en.e = bad_addr(a, 32'h0); en.d = ref_word(a, 32'h0); en.due = edge_n + 1;
      q2.push_back(en); acc2++;
      en.e = bad_addr(a, BASE1); en.d = ref_word(a, BASE1); en.due = edge_n;
      q1.push_back(en); acc1++;
    end
    if (w) mdl_mem[wadr] = wdat;
    @(negedge clk);
    if (v1 === 1'b1) resp1++;
    if (v2 === 1'b1) resp2++;
    ev = 1'b0; ed = '0; ee = 1'b0;
    if (q2.size() > 0 && q2[0].due == edge_n) begin
      ev = 1'b1; ed = q2[0].d; ee = q2[0].e;
      void'(q2.pop_front());
    end
    chk("valid2", v2, ev);
    chk("data2", d2, ed);
    chk("err2", e2, ee);
    ev = 1'b0; ed = '0; ee = 1'b0;
    if (q1.size() > 0 && q1[0].due == edge_n) begin
      ev = 1'b1; ed = q1[0].d; ee = q1[0].e;
      void'(q1.pop_front());
    end
    chk("valid1", v1, ev);
    chk("data1", d1, ed);
    chk("err1", e1, ee);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
  endtask

  task automatic req(input logic [31:0] a);
    step(1'b1, a, 1'b0, 1'b0, 10'd0, 32'h0);
  endtask

  task automatic do_reset();
    pv = 1'b0; fl = 1'b0; we = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_v2", v2, 1'b0); chk("rst_d2", d2, 32'h0); chk("rst_e2", e2, 1'b0);
    chk("rst_v1", v1, 1'b0); chk("rst_d1", d1, 32'h0); chk("rst_e1", e1, 1'b0);
    q1.delete();
    q2.delete();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("init_v2", v2, 1'b0); chk("init_d2", d2, 32'h0); chk("init_e2", e2, 1'b0);
    chk("init_v1", v1, 1'b0); chk("init_d1", d1, 32'h0); chk("init_e1", e1, 1'b0);
    rst_n = 1'b1;

    // Preload the whole ROM through the loader port.
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] val;
      val = (i < 4) ? 32'h11 * 32'(i + 1) : $urandom;
      step(1'b0, 32'h0, 1'b0, 1'b1, 10'(i), val);
    end
    idle(1);

    // Back-to-back fetches of mem[0..3].
    req(32'h0); req(32'h4); req(32'h8); req(32'hC);
    idle(3);

    // Misaligned, out of range, last word, far out of range.
    req(32'h6);         idle(2);
    req(32'h1000);      idle(2);
    req(32'hFFC);       idle(2);
    req(32'hFFFF_FFFC); idle(2);
    req(32'h0000_00FC); idle(2);

    // Flush one edge after an accept kills that response; the next request is normal.
    req(32'h0);
    step(1'b1, 32'h8, 1'b1, 1'b0, 10'd0, 32'h0);
    req(32'h4);
    idle(3);

    // Loader write while a request is held: not accepted that cycle, new data after.
    step(1'b1, 32'h14, 1'b0, 1'b1, 10'd5, 32'hAAAA_5555);
    req(32'h14);
    idle(3);

    // Reset with requests in flight.
    req(32'h0);
    req(32'h4);
    do_reset();
    idle(4);
    req(32'h0);
    req(32'h104);
    idle(3);

    // Streaming sweep with random idle gaps: every accept gets exactly one response.
    acc1 = 0; acc2 = 0; resp1 = 0; resp2 = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else req(rand_addr());
    end
    idle(4);
    chk("count1", 32'(resp1), 32'(acc1));
    chk("count2", 32'(resp2), 32'(acc2));

    // Mixed random traffic with flushes and loader writes.
    for (int i = 0; i < 300; i++) begin
      logic        v, f, w;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 15) == 0);
      w = ($urandom_range(0, 15) == 0);
      step(v, rand_addr(), f, w, 10'($urandom_range(0, 1023)), $urandom);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
